// File: rtl/obs_pkg.sv
// Shared parameters and FSM state type for the parity-split GF(2) multiplier.
// N: operand width, H: half width (one parity half), P: sub-product width.
package obs_pkg;

  localparam int unsigned N = 22;
  localparam int unsigned H = N / 2;
  localparam int unsigned P = 2 * H - 1;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_e;

endpackage

// File: rtl/gf2_mul_serial_11bit.sv
// Bit-serial carry-less (GF(2), unreduced) multiplier, MSB-first, one step per cycle.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (returns to idle)
//   start      : begin a product; the first step is taken in the same cycle
//   a, b       : W-bit operands, must be held for the whole product
//   busy       : a product is in progress (after the first step)
//   done       : high in the cycle that takes the last step; prod is valid then
//   prod       : 2W-1 bit product, combinational, meaningful only with done
module gf2_mul_serial_11bit
  import obs_pkg::*;
#(
  parameter int unsigned W = H
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-2:0] prod
);

  localparam int unsigned BW = $clog2(W);
  localparam logic [BW-1:0] LastBit = BW'(W - 1);

  // Before the final step the accumulator has degree <= 2W-3, so its top bit is
  // only ever produced by the final step and never needs storing.
  logic [2*W-3:0] acc_q;
  logic [BW-1:0]  bit_q;
  logic           busy_q;

  logic           step;
  logic [BW-1:0]  sel;
  logic [2*W-2:0] acc_nxt;

  always_comb begin
    step    = start | busy_q;
    sel     = LastBit - bit_q;
    acc_nxt = {acc_q, 1'b0} ^ (b[sel] ? {{(W - 1){1'b0}}, a} : '0);
    done    = step && (bit_q == LastBit);
    prod    = acc_nxt;
    busy    = busy_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q  <= '0;
      bit_q  <= '0;
      busy_q <= 1'b0;
    end else if (step) begin
      if (done) begin
        acc_q  <= '0;
        bit_q  <= '0;
        busy_q <= 1'b0;
      end else begin
        acc_q  <= acc_nxt[2*W-3:0];
        bit_q  <= bit_q + 1'b1;
        busy_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/obs_split_sched_22bit.sv
// Parity-split GF(2) multiplier scheduler: splits A and B into even/odd-bit halves
// and computes the four half products Ae*Be, Ae*Bo, Ao*Be, Ao*Bo back to back on
// one shared bit-serial multiplier (44 cycles total).
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   A_in, B_in          : N-bit operands, captured when in_valid && in_ready
//   in_valid, in_ready  : operand handshake (ready only in IDLE)
//   B2_out1..B2_out4    : P-bit sub-products, stable while out_valid
//   out_valid, out_ready: result handshake (valid only in DONE)
module obs_split_sched_22bit
  import obs_pkg::*;
#(
  parameter int unsigned N = obs_pkg::N,
  parameter int unsigned H = obs_pkg::H,
  parameter int unsigned P = obs_pkg::P
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] A_in,
  input  logic [N-1:0] B_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [P-1:0] B2_out1,
  output logic [P-1:0] B2_out2,
  output logic [P-1:0] B2_out3,
  output logic [P-1:0] B2_out4,
  output logic         out_valid,
  input  logic         out_ready
);

  state_e       state_q, state_d;
  logic [1:0]   idx_q;
  logic [N-1:0] a_q, b_q;
  logic [P-1:0] prod_q [4];

  logic [H-1:0] ae, ao, be, bo;
  logic [H-1:0] op_a, op_b;
  logic         mul_start, mul_busy, mul_done;
  logic [P-1:0] mul_prod;

  always_comb begin
    for (int k = 0; k < int'(H); k++) begin
      ae[k] = a_q[2*k];
      ao[k] = a_q[2*k+1];
      be[k] = b_q[2*k];
      bo[k] = b_q[2*k+1];
    end
    // idx order: 0 AeBe, 1 AeBo, 2 AoBe, 3 AoBo
    op_a = idx_q[1] ? ao : ae;
    op_b = idx_q[0] ? bo : be;
  end

  // Kick the multiplier whenever it sits idle in MUL so products run back to back.
  assign mul_start = (state_q == MUL) && !mul_busy;

  gf2_mul_serial_11bit #(
    .W(H)
  ) u_mul (
    .clk  (clk),
    .rst_n(rst_n),
    .start(mul_start),
    .a    (op_a),
    .b    (op_b),
    .busy (mul_busy),
    .done (mul_done),
    .prod (mul_prod)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = MUL;
      end
      MUL: begin
        if (mul_done && (idx_q == 2'd3)) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      for (int i = 0; i < 4; i++) prod_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && in_valid) begin
        a_q   <= A_in;
        b_q   <= B_in;
        idx_q <= '0;
      end
      if (mul_done) begin
        prod_q[idx_q] <= mul_prod;
        idx_q         <= idx_q + 1'b1;
      end
    end
  end

  assign B2_out1 = prod_q[0];
  assign B2_out2 = prod_q[1];
  assign B2_out3 = prod_q[2];
  assign B2_out4 = prod_q[3];

endmodule

// File: tb/tb_obs_split_sched_22bit.sv
// Self-checking bench for obs_split_sched_22bit: directed cases, backpressure,
// mid-operation reset and 1000 random operand pairs against a software model.
module tb_obs_split_sched_22bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [21:0] A_in, B_in;
  logic        in_valid, in_ready;
  logic [20:0] B2_out1, B2_out2, B2_out3, B2_out4;
  logic        out_valid, out_ready;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  obs_split_sched_22bit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A_in     (A_in),
    .B_in     (B_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .B2_out1  (B2_out1),
    .B2_out2  (B2_out2),
    .B2_out3  (B2_out3),
    .B2_out4  (B2_out4),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // Plain carry-less multiply of two w-bit values.
  function automatic logic [63:0] clmul(input logic [31:0] x, input logic [31:0] y, input int w);
    logic [63:0] r = '0;
    for (int i = 0; i < w; i++) if (y[i]) r = r ^ ({32'd0, x} << i);
    return r;
  endfunction

  function automatic logic [10:0] half(input logic [21:0] v, input int ofs);
    logic [10:0] r;
    for (int k = 0; k < 11; k++) r[k] = v[2*k+ofs];
    return r;
  endfunction

  function automatic logic [63:0] spread(input logic [20:0] p);
    logic [63:0] r = '0;
    for (int k = 0; k < 21; k++) r[2*k] = p[k];
    return r;
  endfunction

  // Overlap combiner: A*B = P1(x^2) + x*(P2+P3)(x^2) + x^2*P4(x^2).
  function automatic logic [63:0] combine(input logic [20:0] p1, p2, p3, p4);
    return spread(p1) ^ (spread(p2 ^ p3) << 1) ^ (spread(p4) << 2);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [21:0] a, input logic [21:0] b);
    @(negedge clk);
    A_in     = a;
    B_in     = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    A_in     = 22'($urandom);
    B_in     = 22'($urandom);
  endtask

  // Runs 44 cycles after acceptance, disturbing inputs that must be ignored.
  task automatic wait_done(input bit noisy);
    bit early = 1'b0;
    for (int i = 1; i <= 44; i++) begin
      @(negedge clk);
      if (i < 44 && out_valid) early = 1'b1;
      A_in = 22'($urandom);
      B_in = 22'($urandom);
      if (noisy && i < 40) begin
        out_ready = 1'($urandom);
        in_valid  = 1'($urandom);
      end else begin
        out_ready = 1'b0;
        in_valid  = 1'b0;
      end
    end
    check("early_valid", {63'd0, early}, 64'd0);
    check("latency44", {63'd0, out_valid}, 64'd1);
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
  endtask

  task automatic check_products(input logic [21:0] a, input logic [21:0] b);
    check("prod1", {43'd0, B2_out1}, clmul({21'd0, half(a, 0)}, {21'd0, half(b, 0)}, 11));
    check("prod2", {43'd0, B2_out2}, clmul({21'd0, half(a, 0)}, {21'd0, half(b, 1)}, 11));
    check("prod3", {43'd0, B2_out3}, clmul({21'd0, half(a, 1)}, {21'd0, half(b, 0)}, 11));
    check("prod4", {43'd0, B2_out4}, clmul({21'd0, half(a, 1)}, {21'd0, half(b, 1)}, 11));
    check("combined", combine(B2_out1, B2_out2, B2_out3, B2_out4),
          clmul({10'd0, a}, {10'd0, b}, 22));
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_ready", {63'd0, in_ready}, 64'd1);
    check("idle_valid", {63'd0, out_valid}, 64'd0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_ready"}, {63'd0, in_ready}, 64'd1);
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_outs"}, {B2_out1, B2_out2, B2_out3}, 64'd0);
    check({tag, "_out4"}, {43'd0, B2_out4}, 64'd0);
  endtask

  initial begin
    logic [20:0] s1, s2, s3, s4;
    logic [21:0] ra, rb;
    rst_n     = 1'b0;
    A_in      = '0;
    B_in      = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_cleared("reset");

    // 1 * 1
    start_op(22'h000001, 22'h000001);
    wait_done(1'b0);
    check("one_p1", {43'd0, B2_out1}, 64'h1);
    check("one_p234", {B2_out2, B2_out3, B2_out4}, 64'h0);
    check_products(22'h000001, 22'h000001);
    consume();

    // x * x
    start_op(22'h000002, 22'h000002);
    wait_done(1'b0);
    check("x_p4", {43'd0, B2_out4}, 64'h1);
    check("x_p123", {B2_out1, B2_out2, B2_out3}, 64'h0);
    check("x_comb", combine(B2_out1, B2_out2, B2_out3, B2_out4), 64'h4);
    consume();

    // all ones
    start_op(22'h3FFFFF, 22'h3FFFFF);
    wait_done(1'b0);
    check("ones_p1", {43'd0, B2_out1}, 64'h155555);
    check("ones_p2", {43'd0, B2_out2}, 64'h155555);
    check("ones_p3", {43'd0, B2_out3}, 64'h155555);
    check("ones_p4", {43'd0, B2_out4}, 64'h155555);
    check_products(22'h3FFFFF, 22'h3FFFFF);

    // Backpressure in DONE with a competing in_valid
    s1 = B2_out1;
    s2 = B2_out2;
    s3 = B2_out3;
    s4 = B2_out4;
    in_valid = 1'b1;
    A_in     = 22'h12345;
    B_in     = 22'h2ABCD;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", {63'd0, out_valid}, 64'd1);
      check("bp_ready", {63'd0, in_ready}, 64'd0);
      check("bp_stable", {1'b0, B2_out1, B2_out2, B2_out3}, {1'b0, s1, s2, s3});
      check("bp_stable4", {43'd0, B2_out4}, {43'd0, s4});
    end
    in_valid = 1'b0;
    consume();

    // Reset at MUL cycle 20
    start_op(22'h2F0F0F, 22'h15A5A5);
    for (int i = 0; i < 20; i++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_cleared("midreset");
    start_op(22'h2F0F0F, 22'h15A5A5);
    wait_done(1'b0);
    check_products(22'h2F0F0F, 22'h15A5A5);
    consume();

    // Random pairs with noisy handshake inputs during MUL
    for (int n = 0; n < 1000; n++) begin
      ra = 22'($urandom);
      rb = 22'($urandom);
      start_op(ra, rb);
      wait_done(1'b1);
      check_products(ra, rb);
      consume();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
